// File: rtl/nand_share_arbiter_pkg.sv
// Shared definitions for the NAND-sharing arbiter: FSM state encodings,
// the op_count width and a saturating increment helper.
`ifndef NAND_SHARE_ARBITER_PKG_SV
`define NAND_SHARE_ARBITER_PKG_SV

package nand_share_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   localparam int OPCNT_W = 16;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [OPCNT_W-1:0] sat_inc(input logic [OPCNT_W-1:0] v);
      return (v == '1) ? v : v + OPCNT_W'(1);
   endfunction

endpackage

`endif

// File: rtl/nand_share_arbiter_nand_unit.sv
// Registered bitwise NAND datapath shared by all requesters.
module nand_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   logic [WIDTH-1:0] y_d, y_q;

   // Load a fresh result only when enabled, otherwise hold.
   always_comb begin
      y_d = y_q;
      if (en) y_d = ~(a & b);
   end

   // Result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) y_q <= '0;
      else        y_q <= y_d;
   end

   assign y = y_q;

endmodule

// File: rtl/nand_share_arbiter.sv
// Round-robin arbiter sharing one registered NAND unit among N_REQ requesters.
// One operation in flight; IDLE -> EXEC -> RESP -> IDLE.
// Optional feature: define NAND_ARB_STATS_EN to add the saturating op_count output.
module nand_share_arbiter
   import nand_share_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic                   rsp_valid,
   output logic [ID_W-1:0]        rsp_id,
   output logic [WIDTH-1:0]       rsp_data,
   input  logic                   rsp_ready,
   output logic                   busy
`ifdef NAND_ARB_STATS_EN
   ,
   output logic [OPCNT_W-1:0]     op_count
`endif
);

   state_e           state_q, state_d;
   logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [ID_W-1:0]  win_id;
   logic             win_found;
   logic             nand_en;
   logic [WIDTH-1:0] nand_y;

   // Winner search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      int idx;
      win_found = 1'b0;
      win_id    = '0;
      idx       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = (int'(rr_ptr_q) + k) % N_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   // Next state, grant, operand capture and pointer advance.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      a_d       = a_q;
      b_d       = b_q;
      req_ready = '0;
      nand_en   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Grant is suppressed while reset is asserted.
            if (win_found && rst_n) begin
               req_ready[win_id] = 1'b1;
               state_d  = ST_EXEC;
               id_d     = win_id;
               a_d      = req_a[int'(win_id)*WIDTH +: WIDTH];
               b_d      = req_b[int'(win_id)*WIDTH +: WIDTH];
               rr_ptr_d = (int'(win_id) == N_REQ-1) ? '0 : win_id + ID_W'(1);
            end
         end
         ST_EXEC: begin
            nand_en = 1'b1;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers: state, pointer and owner index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
      end
   end

   // Operand capture; data only, no reset needed.
   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   nand_unit #(.WIDTH(WIDTH)) u_nand (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (nand_en),
      .a    (a_q),
      .b    (b_q),
      .y    (nand_y)
   );

   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_id    = rsp_valid ? id_q   : '0;
   assign rsp_data  = rsp_valid ? nand_y : '0;
   assign busy      = (state_q != ST_IDLE);

`ifdef NAND_ARB_STATS_EN
   logic [OPCNT_W-1:0] op_count_q, op_count_d;

   // Count completed responses, saturating.
   always_comb begin
      op_count_d = op_count_q;
      if (rsp_valid && rsp_ready) op_count_d = sat_inc(op_count_q);
   end

   // Completed-response counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) op_count_q <= '0;
      else        op_count_q <= op_count_d;
   end

   assign op_count = op_count_q;
`endif

endmodule
